// File: rtl/universal_shift_reg_if.sv
// Control/data bundle for universal_shift_reg.
// The master modport drives the requests and the slave modport drives the register outputs.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             i_en;
  logic [2:0]       i_mode;
  logic             i_sin_lo;
  logic             i_sin_hi;
  logic [WIDTH-1:0] i_pdata;
  logic             i_start;
  logic [CNT_W-1:0] i_burst_len;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_qbar;
  logic             o_sout_lo;
  logic             o_sout_hi;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_en, i_mode, i_sin_lo, i_sin_hi, i_pdata, i_start, i_burst_len,
    input  o_q, o_qbar, o_sout_lo, o_sout_hi, o_busy, o_done
  );

  modport slave (
    input  i_en, i_mode, i_sin_lo, i_sin_hi, i_pdata, i_start, i_burst_len,
    output o_q, o_qbar, o_sout_lo, o_sout_hi, o_busy, o_done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register with direct modes and a burst sequencer
// that runs N back-to-back shifts from a single start pulse.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic                  clk,
  input logic                  rst,
  universal_shift_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bmode;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;

  function automatic logic f_is_shift(input logic [2:0] m);
    case (m)
      3'b001, 3'b010, 3'b100, 3'b101, 3'b110: f_is_shift = 1'b1;
      default:                                f_is_shift = 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] f_next(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] pd,
    input logic             sl,
    input logic             sh
  );
    case (m)
      3'b000:  f_next = cur;
      3'b001:  f_next = {cur[WIDTH-2:0], sl};
      3'b010:  f_next = {sh, cur[WIDTH-1:1]};
      3'b011:  f_next = pd;
      3'b100:  f_next = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  f_next = {cur[0], cur[WIDTH-1:1]};
      3'b110:  f_next = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b111:  f_next = {WIDTH{1'b0}};
      default: f_next = cur;
    endcase
  endfunction

  assign w_accept = bus.i_start && (bus.i_burst_len != CNT_ZERO) && f_is_shift(bus.i_mode);

  // Burst FSM and shift datapath; start wins over en in IDLE, and q holds on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= {WIDTH{1'b0}};
      r_cnt   <= CNT_ZERO;
      r_bmode <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bmode <= bus.i_mode;
            r_cnt   <= bus.i_burst_len;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else if (bus.i_en) begin
            r_q <= f_next(bus.i_mode, r_q, bus.i_pdata, bus.i_sin_lo, bus.i_sin_hi);
          end else begin
            r_q <= r_q;
          end
        end
        S_RUN: begin
          r_q   <= f_next(r_bmode, r_q, bus.i_pdata, bus.i_sin_lo, bus.i_sin_hi);
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // qbar and the serial taps follow q in the same cycle.
  assign bus.o_q       = r_q;
  assign bus.o_qbar    = ~r_q;
  assign bus.o_sout_lo = r_q[0];
  assign bus.o_sout_hi = r_q[WIDTH-1];
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg at WIDTH=4.
module tb_universal_shift_reg;
  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  universal_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [3:0] exp);
    logic [3:0] nb;
    nb = ~exp;
    chk({tag, "_q"},    {28'd0, bus.o_q},    {28'd0, exp});
    chk({tag, "_qbar"}, {28'd0, bus.o_qbar}, {28'd0, nb});
    chk({tag, "_slo"},  {31'd0, bus.o_sout_lo}, {31'd0, exp[0]});
    chk({tag, "_shi"},  {31'd0, bus.o_sout_hi}, {31'd0, exp[3]});
  endtask

  task automatic chk_st(input string tag, input logic busy, input logic done);
    chk({tag, "_busy"}, {31'd0, bus.o_busy}, {31'd0, busy});
    chk({tag, "_done"}, {31'd0, bus.o_done}, {31'd0, done});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic direct(input logic en, input logic [2:0] mode, input logic [3:0] pd,
                        input logic sl, input logic sh);
    bus.i_en     = en;
    bus.i_mode   = mode;
    bus.i_pdata  = pd;
    bus.i_sin_lo = sl;
    bus.i_sin_hi = sh;
    bus.i_start  = 1'b0;
    tick();
  endtask

  task automatic start_burst(input logic [2:0] mode, input logic [2:0] len);
    bus.i_start     = 1'b1;
    bus.i_mode      = mode;
    bus.i_burst_len = len;
    bus.i_en        = 1'b0;
    tick();
    bus.i_start = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_mode = 3'b000;
    bus.i_sin_lo = 1'b0;
    bus.i_sin_hi = 1'b0;
    bus.i_pdata = 4'b0000;
    bus.i_start = 1'b0;
    bus.i_burst_len = 3'd0;
    tick();
    tick();
    chk_q("rst", 4'b0000);
    chk_st("rst", 1'b0, 1'b0);
    rst = 1'b0;

    direct(1'b1, 3'b011, 4'b1011, 1'b0, 1'b0); chk_q("load", 4'b1011);
    direct(1'b1, 3'b001, 4'b0000, 1'b0, 1'b0); chk_q("shup", 4'b0110);
    direct(1'b1, 3'b010, 4'b0000, 1'b0, 1'b1); chk_q("shdn", 4'b1011);
    direct(1'b0, 3'b111, 4'b0000, 1'b0, 1'b0); chk_q("hold", 4'b1011);
    direct(1'b1, 3'b011, 4'b1001, 1'b0, 1'b0);
    direct(1'b1, 3'b100, 4'b0000, 1'b0, 1'b0); chk_q("rotup", 4'b0011);
    direct(1'b1, 3'b011, 4'b1001, 1'b0, 1'b0);
    direct(1'b1, 3'b101, 4'b0000, 1'b0, 1'b0); chk_q("rotdn", 4'b1100);
    direct(1'b1, 3'b011, 4'b1000, 1'b0, 1'b0);
    direct(1'b1, 3'b110, 4'b0000, 1'b0, 1'b0); chk_q("asr1", 4'b1100);
    direct(1'b1, 3'b110, 4'b0000, 1'b0, 1'b0); chk_q("asr2", 4'b1110);
    direct(1'b1, 3'b111, 4'b0000, 1'b0, 1'b0); chk_q("clr", 4'b0000);

    // Burst of 3 up-shifts; en/clear pulses during RUN must be ignored.
    direct(1'b1, 3'b011, 4'b0001, 1'b0, 1'b0);
    bus.i_sin_lo = 1'b0;
    start_burst(3'b001, 3'd3);
    chk_q("b_acc", 4'b0001); chk_st("b_acc", 1'b1, 1'b0);
    bus.i_en = 1'b1; bus.i_mode = 3'b111;
    tick(); chk_q("b_s1", 4'b0010); chk_st("b_s1", 1'b1, 1'b0);
    tick(); chk_q("b_s2", 4'b0100); chk_st("b_s2", 1'b1, 1'b0);
    tick(); chk_q("b_s3", 4'b1000); chk_st("b_s3", 1'b0, 1'b1);
    bus.i_en = 1'b0; bus.i_mode = 3'b000;
    tick(); chk_q("b_post", 4'b1000); chk_st("b_post", 1'b0, 1'b0);

    // Reset mid-burst abandons the burst without a done pulse.
    direct(1'b1, 3'b011, 4'b1111, 1'b0, 1'b0);
    bus.i_sin_hi = 1'b0;
    start_burst(3'b010, 3'd4);
    tick(); chk_q("rmb_s1", 4'b0111);
    tick(); chk_q("rmb_s2", 4'b0011); chk_st("rmb_s2", 1'b1, 1'b0);
    rst = 1'b1;
    tick(); chk_q("rmb_rst", 4'b0000); chk_st("rmb_rst", 1'b0, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_done || bus.o_busy) seen = 1'b1;
    end
    chk("rmb_quiet", {31'd0, seen}, 32'd0);
    chk_q("rmb_end", 4'b0000);

    // Rejected starts: zero length, then a non-shift mode acting as a direct load.
    direct(1'b1, 3'b011, 4'b0110, 1'b0, 1'b0);
    bus.i_start = 1'b1; bus.i_mode = 3'b001; bus.i_burst_len = 3'd0; bus.i_en = 1'b0;
    tick(); chk_q("rej0", 4'b0110); chk_st("rej0", 1'b0, 1'b0);
    bus.i_start = 1'b1; bus.i_mode = 3'b011; bus.i_burst_len = 3'd3; bus.i_en = 1'b1;
    bus.i_pdata = 4'b0101;
    tick(); chk_q("rejld", 4'b0101); chk_st("rejld", 1'b0, 1'b0);
    bus.i_start = 1'b0; bus.i_en = 1'b0;
    tick(); chk_st("rejld_n", 1'b0, 1'b0);

    // Back-to-back: second start accepted in the done cycle of the first.
    start_burst(3'b100, 3'd2);
    chk_st("bb_acc", 1'b1, 1'b0);
    tick(); chk_q("bb_s1", 4'b1010); chk_st("bb_s1", 1'b1, 1'b0);
    tick(); chk_q("bb_s2", 4'b0101); chk_st("bb_s2", 1'b0, 1'b1);
    start_burst(3'b101, 3'd1);
    chk_q("bb2_acc", 4'b0101); chk_st("bb2_acc", 1'b1, 1'b0);
    tick(); chk_q("bb2_s1", 4'b1010); chk_st("bb2_s1", 1'b0, 1'b1);
    tick(); chk_st("bb2_post", 1'b0, 1'b0);

    // Length above WIDTH: rotate by 5 equals rotate by 1.
    direct(1'b1, 3'b011, 4'b0011, 1'b0, 1'b0);
    start_burst(3'b100, 3'd5);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      n++;
      if (bus.o_done) seen = 1'b1;
    end
    chk("l5_done", {31'd0, seen}, 32'd1);
    chk("l5_cycles", n, 32'd5);
    chk_q("l5", 4'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register, the successor to the team's fixed 4-bit left/right shifter.
- Width: generic.
- Direct modes: hold, shift up/down, parallel load, rotate up/down, arithmetic shift down, clear.
- Burst sequencer: performs N back-to-back shifts from a single start pulse, with busy/done status.
- Used as a serialiser/deserialiser and general data-path shifter in the team's sequential library.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH)+1, width of burst_len and the internal burst counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
en  input  1  enables one direct-mode operation this cycle; ignored while busy.
mode  input  3  operation select (encoding below).
sin_lo  input  1  serial input into bit 0 on up-shifts.
sin_hi  input  1  serial input into bit WIDTH-1 on logical down-shifts.
pdata  input  WIDTH  parallel load data.
start  input  1  burst request, sampled only in IDLE.
burst_len  input  CNT_W  number of shifts in the burst.
q  output  WIDTH  register contents.
qbar  output  WIDTH  bitwise complement of q.
sout_lo  output  1  q[0].
sout_hi  output  1  q[WIDTH-1].
busy  output  1  high while a burst is in progress.
done  output  1  one-cycle pulse marking burst completion.

Behaviour:
- Mode encoding:
  - 000 hold.
  - 001 shift up: q <= {q[WIDTH-2:0], sin_lo}.
  - 010 shift down: q <= {sin_hi, q[WIDTH-1:1]}.
  - 011 parallel load: q <= pdata.
  - 100 rotate up: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate down: q <= {q[0], q[WIDTH-1:1]}.
  - 110 arithmetic shift down: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
  - 111 clear: q <= 0.
- Shift-class modes are 001, 010, 100, 101, 110.
- Output derivation:
  - qbar, sout_lo and sout_hi are combinational from q.
  - qbar equals ~q in every cycle, with no one-cycle lag.
- Reset: when rst=1 at a clock edge, all of the following take effect:
  - q=0 (so qbar=all ones, sout_lo=0, sout_hi=0).
  - busy=0, done=0.
  - FSM goes to IDLE and the burst counter is cleared.
  - rst overrides start, en and any burst in progress.
- FSM states: IDLE and RUN.
- IDLE, burst accept. A start is accepted when start=1, burst_len != 0 and mode is shift-class. On acceptance:
  - latch bmode=mode and cnt=burst_len;
  - go to RUN with busy=1 from the next cycle;
  - q is unchanged on the accept edge;
  - en is ignored on the accept cycle (start wins).
- IDLE, start not accepted. A start with burst_len=0 or a non-shift mode is ignored:
  - no busy and no done;
  - the cycle behaves as a direct cycle.
- IDLE, direct cycle: if en=1, apply mode once at the edge; if en=0, hold q.
- RUN, per edge:
  - apply one bmode shift, using live sin_lo/sin_hi;
  - decrement cnt;
  - en, start, mode and burst_len are ignored.
- RUN, last shift: on the edge where cnt=1, perform the final shift, go to IDLE, busy <= 0, done <= 1.
- done behaviour:
  - done is high exactly one cycle, coincident with the final q value.
  - In every other cycle done=0.
- Burst latency:
  - start sampled at edge k; shifts occur at edges k+1 .. k+L.
  - busy is high in the cycles after edges k .. k+L-1.
  - done is high in the cycle after edge k+L.
- Back-to-back bursts: a new start may be accepted in the cycle done is high, because the FSM is already in IDLE.
- burst_len > WIDTH is legal; the shifts simply continue (e.g. rotate by WIDTH+1 equals rotate by 1).
- Reset mid-burst: the burst is abandoned, q=0, and no done pulse is ever produced for it.

Test Plan:
- Reset, WIDTH=4: assert rst for 2 cycles -> q=0000, qbar=1111, busy=0, done=0; qbar stays ~q on every subsequent cycle.
- Direct load and shifts: en=1, mode=011, pdata=1011 -> q=1011; then mode=001, sin_lo=0 -> 0110; then mode=010, sin_hi=1 -> 1011; then en=0 -> holds 1011.
- Rotate, arithmetic shift and clear:
  - q=1001, mode=100 -> 0011.
  - Reload q=1001, mode=101 -> 1100.
  - Load 1000, mode=110 twice -> 1100 then 1110.
  - mode=111 -> 0000.
- Burst: q=0001, start=1, mode=001, burst_len=3, sin_lo=0 ->
  - busy high 3 cycles, q steps 0010, 0100, 1000;
  - done high one cycle with q=1000, then busy=0;
  - en=1, mode=111 pulses during the burst have no effect.
- Reset mid-burst: q=1111, burst mode=010, len=4, sin_hi=0; after 2 shifts (q=0011) assert rst -> q=0000, busy=0, no done pulse in the following 5 cycles.
- Rejected starts:
  - start with burst_len=0, en=0 -> no busy, q unchanged.
  - start with mode=011, en=1, pdata=0101 -> no busy, q=0101.
  - start accepted in the done cycle of a prior burst -> second burst runs with correct busy/done timing.
